sap_registrador_universal: RTL and testbench
============================================

# sap_registrador_universal

Parametrised universal register for the SAP-1 datapath: the next-generation replacement for the fixed 4-bit tristate register. It adds configurable width, synchronous load, shift, rotate, increment/decrement and sync-clear, plus a registered carry flag and a combinational zero flag. It serves as accumulator, B register, or program/memory-address counter on the shared W bus. Q_ULA always feeds the ALU; Q_OUT drives the bus only when enabled.

## Interface
- WIDTH, 8: register width in bits (≥ 2).
- RESET_VALUE, 0: value loaded on asynchronous reset (WIDTH bits).
- clock  in  1  single clock; all state changes on rising edge.
- clear_n  in  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low.
- enable_in  in  1  operation strobe; when 0 the register holds regardless of op.
- op  in  3  operation select, sampled only when enable_in=1.
- D  in  WIDTH  parallel load data.
- serial_in  in  1  bit shifted in on SHL/SHR.
- enable_output  in  1  bus drive enable for Q_OUT.
- Q_OUT  out  WIDTH  bus output (gated, see Configuration).
- Q_ULA  out  WIDTH  ungated register contents to ALU.
- carry  out  1  registered carry/borrow/shifted-out bit.
- zero  out  1  combinational, 1 when register == 0.

## Operation
- op encoding (when enable_in=1): 000 HOLD; 001 LOAD (R←D, carry←0); 010 SHL (R←{R[W-2:0],serial_in}, carry←R[W-1]); 011 SHR (R←{serial_in,R[W-1:1]}, carry←R[0]); 100 INC (R←R+1 mod 2^W, carry←1 iff R was all-ones); 101 DEC (R←R−1 mod 2^W, carry←1 iff R was 0, i.e. borrow); 110 ROL (R←{R[W-2:0],R[W-1]}, carry←R[W-1]); 111 CLR (R←0, carry←0).
- HOLD and enable_in=0: R and carry unchanged.
- Arithmetic: W-bit unsigned; carry computed from the pre-edge R value; wrap-around is the defined behaviour, not an error.
- zero = (R == 0), derived from the current R, not registered.
- Q_ULA = R at all times, independent of enable_output.
- Reset (clear_n=0): R←RESET_VALUE, carry←0 immediately, without waiting for a clock edge; overrides any op in progress; ops resume on the first rising edge after clear_n returns high.
- Reset values: Q_ULA=RESET_VALUE; carry=0; zero=(RESET_VALUE==0); Q_OUT per enable_output/Configuration.

## Timing
- Latency: result of any op visible on Q_ULA/carry/zero one clock edge after the strobe cycle; ops are single-cycle and back-to-back ops are allowed every cycle.
- Q_OUT follows enable_output and R combinationally (no register stage); bus turn-on/off occurs in the same cycle enable_output changes.
- enable_in, op, D and serial_in must be stable around the rising edge; enable_output may change at any time.
- Simultaneous LOAD with enable_output=1: Q_OUT shows the old value until the edge, then the new value (no bypass from D).

## Configuration
- REG_TRISTATE_EN defined: Q_OUT = R when enable_output=1, otherwise all bits high-impedance ('z'), for a true shared tristate bus.
- REG_TRISTATE_EN undefined: Q_OUT = R when enable_output=1, otherwise all zeros, for OR/mux-based bus builds on FPGA; no 'z' is ever driven.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'h00; pulse clear_n low mid-cycle with R=8'h5A -> R=8'h00, carry=0, zero=1 before the next edge.
- Load + output: LOAD D=8'hA5, enable_output=0 then 1 -> Q_ULA=8'hA5 after 1 edge; Q_OUT='z' (macro defined) or 8'h00 (undefined), then 8'hA5.
- Increment wrap: LOAD 8'hFE, INC, INC -> 8'hFF carry=0, then 8'h00 carry=1 zero=1.
- Decrement borrow: LOAD 8'h00, DEC -> 8'hFF carry=1 zero=0; DEC again -> 8'hFE carry=0.
- Shift/rotate: LOAD 8'h81, SHL serial_in=0 -> 8'h02 carry=1; SHR serial_in=1 -> 8'h81 carry=0; ROL -> 8'h03 carry=1.
- Hold/priority: enable_in=0 with op=111 for 3 cycles -> R unchanged; assert clear_n low during an INC strobe -> R=RESET_VALUE, no increment applied.

Source files
------------

// File: rtl/sap_registrador_universal.sv
// sap_registrador_universal
//   Universal register for the SAP-1 datapath. Serves as accumulator,
//   B register or program/memory-address counter on the shared W bus.
//   Single-cycle ops: hold, load, shift left/right, increment, decrement,
//   rotate left and sync clear. Carry is registered, zero is combinational.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value taken on asynchronous reset
//
// Ports
//   clock          rising-edge clock
//   clear_n        asynchronous active-low reset
//   enable_in      operation strobe; 0 holds regardless of op
//   op             operation select (see op_e)
//   D              parallel load data
//   serial_in      bit shifted in on SHL/SHR
//   enable_output  bus drive enable for Q_OUT
//   Q_OUT          bus output (gated by enable_output)
//   Q_ULA          ungated register contents to the ALU
//   carry          registered carry/borrow/shifted-out bit
//   zero           1 when register == 0 (combinational)
//
// Build option
//   REG_TRISTATE_EN  defined: Q_OUT floats ('z) when not enabled, for a real
//                    tristate bus. Undefined: Q_OUT drives zeros instead, for
//                    OR/mux-based bus builds.
module sap_registrador_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable_in,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in,
  input  logic             enable_output,
  output logic [WIDTH-1:0] Q_OUT,
  output logic [WIDTH-1:0] Q_ULA,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101,
    OP_ROL  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r;
  logic             c;
  logic [WIDTH:0]   inc_sum;

  // Extra MSB of the widened sum is the carry out of R+1 (set only when R was all-ones).
  assign inc_sum = {1'b0, r} + {1'b0, ONE};

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r <= RESET_VALUE;
      c <= 1'b0;
    end else if (enable_in) begin
      case (op_e'(op))
        OP_HOLD: ;
        OP_LOAD: begin r <= D;                         c <= 1'b0;        end
        OP_SHL:  begin r <= {r[WIDTH-2:0], serial_in}; c <= r[WIDTH-1];  end
        OP_SHR:  begin r <= {serial_in, r[WIDTH-1:1]}; c <= r[0];        end
        OP_INC:  begin r <= inc_sum[WIDTH-1:0];        c <= inc_sum[WIDTH]; end
        OP_DEC:  begin r <= r - ONE;                   c <= (r == '0);   end
        OP_ROL:  begin r <= {r[WIDTH-2:0], r[WIDTH-1]}; c <= r[WIDTH-1]; end
        OP_CLR:  begin r <= '0;                        c <= 1'b0;        end
        default: ;
      endcase
    end
  end

  assign Q_ULA = r;
  assign carry = c;
  assign zero  = (r == '0);

  // Bus output is purely combinational: no bypass from D, so a LOAD with the
  // bus enabled shows the old value until the edge.
`ifdef REG_TRISTATE_EN
  assign Q_OUT = enable_output ? r : {WIDTH{1'bz}};
`else
  assign Q_OUT = enable_output ? r : '0;
`endif

endmodule

// File: tb/tb_sap_registrador_universal.sv
module tb_sap_registrador_universal;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       enable_in;
  logic [2:0] op;
  logic [7:0] D;
  logic       serial_in;
  logic       enable_output;
  logic [7:0] Q_OUT;
  logic [7:0] Q_ULA;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         INC  = 3'b100, DEC  = 3'b101, ROL = 3'b110, CLR = 3'b111;

`ifdef REG_TRISTATE_EN
  localparam logic [7:0] OFF_BUS = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] OFF_BUS = 8'h00;
`endif

  sap_registrador_universal #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clock(clock), .clear_n(clear_n), .enable_in(enable_in), .op(op), .D(D),
    .serial_in(serial_in), .enable_output(enable_output), .Q_OUT(Q_OUT),
    .Q_ULA(Q_ULA), .carry(carry), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] r, input logic c);
    chk({tag, ".q"},     Q_ULA,        r);
    chk({tag, ".carry"}, {7'b0, carry}, {7'b0, c});
    chk({tag, ".zero"},  {7'b0, zero},  {7'b0, (r == 8'h00)});
  endtask

  // Strobe one op, then sample 1 time unit after the edge.
  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic si);
    @(negedge clock);
    enable_in = 1'b1; op = o; D = d; serial_in = si;
    @(posedge clock);
    #1;
    enable_in = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0; enable_in = 1'b0; op = HOLD; D = 8'h00;
    serial_in = 1'b0; enable_output = 1'b0;
    #2;
    chk_state("reset", 8'h00, 1'b0);
    chk("reset.qout", Q_OUT, OFF_BUS);
    @(negedge clock); clear_n = 1'b1;

    // Mid-cycle asynchronous reset
    do_op(LOAD, 8'h5A, 1'b0);
    chk_state("load5a", 8'h5A, 1'b0);
    #3 clear_n = 1'b0;
    #1 chk_state("async_clr", 8'h00, 1'b0);
    #1 clear_n = 1'b1;

    // Load and bus output
    do_op(LOAD, 8'hA5, 1'b0);
    chk_state("loada5", 8'hA5, 1'b0);
    chk("qout_off", Q_OUT, OFF_BUS);
    enable_output = 1'b1;
    #1 chk("qout_on", Q_OUT, 8'hA5);
    enable_output = 1'b0;
    #1 chk("qout_off2", Q_OUT, OFF_BUS);

    // Increment wrap
    do_op(LOAD, 8'hFE, 1'b0);
    do_op(INC, 8'h00, 1'b0);
    chk_state("inc1", 8'hFF, 1'b0);
    do_op(INC, 8'h00, 1'b0);
    chk_state("inc_wrap", 8'h00, 1'b1);

    // Decrement borrow
    do_op(LOAD, 8'h00, 1'b0);
    chk_state("load00", 8'h00, 1'b0);
    do_op(DEC, 8'h00, 1'b0);
    chk_state("dec_borrow", 8'hFF, 1'b1);
    do_op(DEC, 8'h00, 1'b0);
    chk_state("dec2", 8'hFE, 1'b0);

    // Shift / rotate
    do_op(LOAD, 8'h81, 1'b0);
    do_op(SHL, 8'h00, 1'b0);
    chk_state("shl", 8'h02, 1'b1);
    do_op(SHR, 8'h00, 1'b1);
    chk_state("shr", 8'h81, 1'b0);
    do_op(ROL, 8'h00, 1'b0);
    chk_state("rol", 8'h03, 1'b1);

    // enable_in=0 holds even with op=CLR
    @(negedge clock); op = CLR; D = 8'hFF;
    repeat (3) @(posedge clock);
    #1 chk_state("hold_en0", 8'h03, 1'b1);
    do_op(HOLD, 8'hFF, 1'b1);
    chk_state("hold_op", 8'h03, 1'b1);
    do_op(CLR, 8'hFF, 1'b1);
    chk_state("clr", 8'h00, 1'b0);

    // Reset overrides an INC strobe
    do_op(LOAD, 8'h10, 1'b0);
    chk_state("load10", 8'h10, 1'b0);
    @(negedge clock); enable_in = 1'b1; op = INC; clear_n = 1'b0;
    @(posedge clock);
    #1 chk_state("clr_vs_inc", 8'h00, 1'b0);
    @(negedge clock); clear_n = 1'b1; enable_in = 1'b0;
    do_op(INC, 8'h00, 1'b0);
    chk_state("inc_after_clr", 8'h01, 1'b0);

    // LOAD with bus enabled: old value until the edge
    @(negedge clock); enable_output = 1'b1; enable_in = 1'b1; op = LOAD; D = 8'h77;
    #1 chk("qout_old", Q_OUT, 8'h01);
    @(posedge clock);
    #1 chk("qout_new", Q_OUT, 8'h77);
    enable_in = 1'b0;
    chk_state("load77", 8'h77, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
